program_loader: RTL

- Boot-time loader for the waverv core.
- Accepts a little-endian byte stream over a valid/ready handshake and assembles it into 32-bit words.
- Writes each word through memory port A (the write side of the port the core fetches from) and holds the core in reset until the image is fully written.
- Sits beside the core top level. Drives memory_write_enable_a, memory_access_address_a and memory_write_data_a while loading, and releases core_hold when done.

---
 rtl/program_loader.sv | 73 +++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader: boot loader that assembles a little-endian byte stream into words,
// writes them through memory port A and holds the core in reset until the image is in.
module program_loader #(
  parameter logic [31:0] ADDRESS_BASE = 32'h0000_0000,
  parameter logic [31:0] ADDRESS_STEP = 32'd4,
  parameter int unsigned MAX_WORDS    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        loader_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        memory_write_enable_a,
  output logic [31:0] memory_access_address_a,
  output logic [31:0] memory_write_data_a,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_error
);
  typedef enum logic [2:0] {IDLE, HEADER, DATA, WRITE, DONE, ERROR} state_t;
  state_t state, next_state;
  logic [1:0]  byte_cnt;
  logic [31:0] word_count;
  logic [23:0] assembly;
  logic [31:0] header;
  logic        accept, last_byte, start_load;
  assign accept     = byte_valid && byte_ready;
  assign last_byte  = accept && byte_cnt == 2'd3;
  assign header     = {byte_data, word_count[31:8]};
  assign start_load = loader_start && (state == IDLE || state == DONE || state == ERROR);
  assign byte_ready            = state == HEADER || state == DATA;
  assign memory_write_enable_a = state == WRITE;
  assign core_hold             = state != DONE;
  assign load_done             = state == DONE;
  assign load_error            = state == ERROR;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERROR: next_state = loader_start ? HEADER : state;
      HEADER: next_state = !last_byte ? HEADER :
                           (header == 32'd0 || header > MAX_WORDS) ? ERROR : DATA;
      DATA:   next_state = last_byte ? WRITE : DATA;
      WRITE:  next_state = word_count == 32'd1 ? DONE : DATA;
      default: next_state = IDLE;
    endcase
  end
  // word_count doubles as the remaining-word counter once the header is in
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      byte_cnt                <= '0;
      word_count              <= '0;
      assembly                <= '0;
      memory_access_address_a <= '0;
      memory_write_data_a     <= '0;
    end else begin
      if (start_load) begin
        byte_cnt                <= '0;
        memory_access_address_a <= ADDRESS_BASE;
      end
      if (accept) byte_cnt <= byte_cnt + 2'd1;
      if (accept && state == HEADER) word_count <= header;
      if (accept && state == DATA) assembly <= {byte_data, assembly[23:8]};
      if (last_byte && state == DATA) memory_write_data_a <= {byte_data, assembly};
      if (state == WRITE) begin
        memory_access_address_a <= memory_access_address_a + ADDRESS_STEP;
        word_count              <= word_count - 32'd1;
      end
    end
endmodule
